// File: rtl/cart_rom_arbiter.sv
// cart_rom_arbiter: shares the cartridge ROM read port between MARIA DMA
// fetches and 6502 CPU fetches. DMA has fixed priority; a saturating
// starvation counter lets the CPU pre-empt DMA after CPU_MAX_WAIT cycles.
// Optional single-entry CPU read cache enabled by `define CART_CPU_CACHE_EN.
module cart_rom_arbiter #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned CPU_MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  input  logic              cache_flush,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RECOVER
  } state_t;

  typedef enum logic {
    OWN_DMA,
    OWN_CPU
  } owner_t;

  localparam logic [7:0] LP_MAX_WAIT = 8'(CPU_MAX_WAIT);

  state_t            r_state;
  owner_t            r_owner;
  logic [7:0]        r_starve_cnt;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_dma_ack;
  logic              r_cpu_ack;
  logic [7:0]        r_dma_rdata;
  logic [7:0]        r_cpu_rdata;
  logic              r_busy;

  logic              w_cpu_wins;
  logic              w_cpu_in_wait;
  logic              w_cpu_done;
  logic              w_cache_hit;
  logic [7:0]        w_cache_data;

  // CPU wins when alone, or when it has waited long enough to override DMA
  assign w_cpu_wins    = cpu_req && (!dma_req || (r_starve_cnt >= LP_MAX_WAIT));
  assign w_cpu_in_wait = (r_state == ST_WAIT) && (r_owner == OWN_CPU);
  assign w_cpu_done    = w_cpu_in_wait && mem_ready;

`ifdef CART_CPU_CACHE_EN
  logic [ADDR_W-1:0] r_cache_tag;
  logic [7:0]        r_cache_data;
  logic              r_cache_valid;

  assign w_cache_hit  = r_cache_valid && (cpu_addr == r_cache_tag);
  assign w_cache_data = r_cache_data;

  // Cache entry: filled by every CPU memory completion, a flush wins over a fill
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cache_tag   <= '0;
      r_cache_data  <= '0;
      r_cache_valid <= 1'b0;
    end else if (cache_flush) begin
      r_cache_valid <= 1'b0;
    end else if (w_cpu_done) begin
      r_cache_tag   <= r_mem_addr;
      r_cache_data  <= mem_rdata;
      r_cache_valid <= 1'b1;
    end
  end
`else
  logic w_unused_flush;

  assign w_cache_hit    = 1'b0;
  assign w_cache_data   = '0;
  assign w_unused_flush = cache_flush;
`endif

  // Starvation counter: counts cycles the CPU waits without owning memory
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (!cpu_req || r_cpu_ack) begin
      r_starve_cnt <= '0;
    end else if (!w_cpu_in_wait && (r_starve_cnt != 8'hFF)) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  // Arbitration FSM with registered memory request, acks, read data and busy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_DMA;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_dma_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_rdata <= '0;
      r_cpu_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_dma_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cpu_wins) begin
            r_owner <= OWN_CPU;
            r_busy  <= 1'b1;
            if (w_cache_hit) begin
              r_cpu_ack   <= 1'b1;
              r_cpu_rdata <= w_cache_data;
              r_state     <= ST_RECOVER;
            end else begin
              r_mem_addr <= cpu_addr;
              r_mem_req  <= 1'b1;
              r_state    <= ST_WAIT;
            end
          end else if (dma_req) begin
            r_owner    <= OWN_DMA;
            r_busy     <= 1'b1;
            r_mem_addr <= dma_addr;
            r_mem_req  <= 1'b1;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_RECOVER;
            if (r_owner == OWN_CPU) begin
              r_cpu_rdata <= mem_rdata;
              r_cpu_ack   <= 1'b1;
            end else begin
              r_dma_rdata <= mem_rdata;
              r_dma_ack   <= 1'b1;
            end
          end
        end
        ST_RECOVER: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign dma_ack   = r_dma_ack;
  assign dma_rdata = r_dma_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cart_rom_arbiter.sv
// Testbench for cart_rom_arbiter: table-driven single/dual request vectors
// plus hand-written sequences for starvation, withdrawal, reset and cache.
module tb_cart_rom_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        dma_req = 1'b0;
  logic [17:0] dma_addr = '0;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        cpu_req = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic        cache_flush = 1'b0;
  logic        busy;

  logic        resp_ready = 1'b0;
  logic        stray_ready = 1'b0;
  logic [7:0]  resp_rdata = '0;
  int          resp_cnt = 0;
  int          lat = 0;

  int checks = 0;
  int errors = 0;

  assign mem_ready = resp_ready | stray_ready;
  assign mem_rdata = resp_rdata;

  cart_rom_arbiter #(.ADDR_W(18), .CPU_MAX_WAIT(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cache_flush(cache_flush), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_fn(input logic [17:0] a);
    case (a)
      18'h1C000: return 8'hA5;
      18'h04000: return 8'h77;
      18'h00010: return 8'hC3;
      18'h3FFFF: return 8'h81;
      18'h00000: return 8'h0F;
      18'h08000: return 8'h3C;
      18'h12345: return 8'hE7;
      default:   return 8'hEE;
    endcase
  endfunction

  // Memory model: answers mem_req after 'lat' negedges with a one-cycle ready
  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_ready = 1'b0;
      resp_cnt   = 0;
    end else if (resp_ready) begin
      resp_ready = 1'b0;
      resp_cnt   = 0;
    end else if (mem_req) begin
      if (resp_cnt >= lat) begin
        resp_ready = 1'b1;
        resp_rdata = mem_fn(mem_addr);
      end else begin
        resp_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cpu_read(input logic [17:0] a, input int l, output bit saw,
                          output logic [17:0] first_addr, output int acyc);
    @(negedge clock);
    lat = l;
    cpu_addr = a;
    cpu_req = 1'b1;
    saw = 1'b0;
    first_addr = '0;
    acyc = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock); #1;
      if (mem_req && !saw) begin
        saw = 1'b1;
        first_addr = mem_addr;
      end
      if (cpu_ack && acyc < 0) begin
        acyc = c;
        cpu_req = 1'b0;
      end
      if (acyc >= 0 && !busy) break;
    end
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic        dreq;
    logic [17:0] daddr;
    logic        creq;
    logic [17:0] caddr;
    int          vlat;
    logic [17:0] exp_addr;
    int          exp_dcyc;
    int          exp_ccyc;
    logic [7:0]  exp_d;
    logic [7:0]  exp_c;
  } vec_t;

  vec_t vt[6];

  initial begin
    bit          saw;
    logic [17:0] faddr;
    int          dn, cn, dcyc, ccyc, done_c;

    vt[0] = '{1'b1, 18'h1C000, 1'b0, 18'h00000, 2, 18'h1C000, 3, -1, 8'hA5, 8'h00};
    vt[1] = '{1'b0, 18'h00000, 1'b1, 18'h04000, 0, 18'h04000, -1, 1, 8'hA5, 8'h77};
    vt[2] = '{1'b1, 18'h3FFFF, 1'b1, 18'h00000, 1, 18'h3FFFF, 2, 6, 8'h81, 8'h0F};
    vt[3] = '{1'b0, 18'h00000, 1'b1, 18'h12345, 3, 18'h12345, -1, 4, 8'h81, 8'hE7};
    vt[4] = '{1'b1, 18'h00000, 1'b1, 18'h3FFFF, 0, 18'h00000, 1, 4, 8'h0F, 8'h81};
    vt[5] = '{1'b1, 18'h12345, 1'b0, 18'h00000, 1, 18'h12345, 2, -1, 8'hE7, 8'h81};

    // Reset state
    #12;
    check("reset_mem_req", 32'(mem_req), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_mem_addr", 32'(mem_addr), 0);
    check("reset_acks", {30'd0, dma_ack, cpu_ack}, 0);
    check("reset_rdata", {16'd0, dma_rdata, cpu_rdata}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven transactions
    for (int v = 0; v < 6; v++) begin
      @(negedge clock);
      lat = vt[v].vlat;
      dma_addr = vt[v].daddr;
      cpu_addr = vt[v].caddr;
      dma_req = vt[v].dreq;
      cpu_req = vt[v].creq;
      saw = 1'b0; faddr = '0; dn = 0; cn = 0; dcyc = -1; ccyc = -1; done_c = -1;
      for (int c = 0; c < 60; c++) begin
        @(posedge clock); #1;
        if (mem_req && !saw) begin saw = 1'b1; faddr = mem_addr; end
        if (dma_ack) begin dn++; dcyc = c; dma_req = 1'b0; end
        if (cpu_ack) begin cn++; ccyc = c; cpu_req = 1'b0; end
        if (!dma_req && !cpu_req && !busy) begin done_c = c; break; end
      end
      dma_req = 1'b0;
      cpu_req = 1'b0;
      check($sformatf("v%0d_timeout", v), 32'(done_c >= 0), 1);
      check($sformatf("v%0d_mem_addr", v), 32'(faddr), 32'(vt[v].exp_addr));
      check($sformatf("v%0d_dma_acks", v), dn, 32'(vt[v].dreq));
      check($sformatf("v%0d_cpu_acks", v), cn, 32'(vt[v].creq));
      check($sformatf("v%0d_dma_ack_cyc", v), dcyc, vt[v].exp_dcyc);
      check($sformatf("v%0d_cpu_ack_cyc", v), ccyc, vt[v].exp_ccyc);
      check($sformatf("v%0d_dma_rdata", v), 32'(dma_rdata), 32'(vt[v].exp_d));
      check($sformatf("v%0d_cpu_rdata", v), 32'(cpu_rdata), 32'(vt[v].exp_c));
      check($sformatf("v%0d_busy_fall", v), done_c, ((dcyc > ccyc) ? dcyc : ccyc) + 1);
    end

    // Request dropped while in WAIT still completes
    @(negedge clock);
    lat = 3; cpu_addr = 18'h00010; cpu_req = 1'b1;
    @(posedge clock); #1;
    check("drop_mem_req", 32'(mem_req), 1);
    cpu_req = 1'b0;
    ccyc = -1; cn = 0;
    for (int c = 1; c < 20; c++) begin
      @(posedge clock); #1;
      if (cpu_ack) begin cn++; ccyc = c; end
      if (ccyc >= 0 && !busy) break;
    end
    check("drop_ack_cyc", ccyc, 4);
    check("drop_ack_cnt", cn, 1);
    check("drop_rdata", 32'(cpu_rdata), 32'h C3);

    // Withdrawn CPU request while DMA owns memory
    @(negedge clock);
    lat = 4; dma_addr = 18'h00000; dma_req = 1'b1;
    dn = 0; cn = 0; done_c = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock); #1;
      if (c == 0) begin cpu_addr = 18'h04000; cpu_req = 1'b1; end
      if (c == 1) cpu_req = 1'b0;
      if (dma_ack) begin dn++; dma_req = 1'b0; end
      if (cpu_ack) cn++;
      if (c > 1 && !dma_req && !busy) begin done_c = c; break; end
    end
    dma_req = 1'b0;
    cpu_req = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      if (cpu_ack) cn++;
    end
    check("wd_timeout", 32'(done_c >= 0), 1);
    check("wd_dma_acks", dn, 1);
    check("wd_cpu_acks", cn, 0);
    check("wd_dma_rdata", 32'(dma_rdata), 32'h0F);
    check("wd_cpu_rdata", 32'(cpu_rdata), 32'hC3);

    // Stray mem_ready in IDLE is ignored
    @(negedge clock);
    stray_ready = 1'b1;
    @(posedge clock); #1;
    check("stray_acks", {30'd0, dma_ack, cpu_ack}, 0);
    check("stray_busy", 32'(busy), 0);
    @(negedge clock);
    stray_ready = 1'b0;

    // Starvation: continuous DMA, CPU must get in once the counter reaches 8
    @(negedge clock);
    lat = 0; dma_addr = 18'h1C000; cpu_addr = 18'h04000;
    dma_req = 1'b1; cpu_req = 1'b1;
    dn = 0; ccyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (dma_ack) dn++;
      if (cpu_ack) begin ccyc = c; cpu_req = 1'b0; dma_req = 1'b0; break; end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    check("starve_ack_cyc", ccyc, 10);
    check("starve_dma_first", dn, 3);
    check("starve_cpu_rdata", 32'(cpu_rdata), 32'h77);
    check("starve_dma_rdata", 32'(dma_rdata), 32'hA5);
    repeat (2) @(posedge clock);
    #1;
    check("starve_idle", 32'(busy), 0);

    // Asynchronous reset in the middle of WAIT
    @(negedge clock);
    lat = 10; dma_addr = 18'h12345; dma_req = 1'b1;
    @(posedge clock); #1;
    check("rst_pre_mem_req", 32'(mem_req), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_acks", {30'd0, dma_ack, cpu_ack}, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_rdata", {16'd0, dma_rdata, cpu_rdata}, 0);
    dma_req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cpu_read(18'h00010, 0, saw, faddr, ccyc);
    check("post_rst_mem_addr", 32'(faddr), 32'h00010);
    check("post_rst_ack_cyc", ccyc, 1);
    check("post_rst_rdata", 32'(cpu_rdata), 32'hC3);

`ifdef CART_CPU_CACHE_EN
    // Cache: miss fills, repeat hits without memory, flush forces a miss
    cpu_read(18'h08000, 1, saw, faddr, ccyc);
    check("cache_miss_mem", 32'(saw), 1);
    check("cache_miss_cyc", ccyc, 2);
    check("cache_miss_data", 32'(cpu_rdata), 32'h3C);
    cpu_read(18'h08000, 1, saw, faddr, ccyc);
    check("cache_hit_nomem", 32'(saw), 0);
    check("cache_hit_cyc", ccyc, 0);
    check("cache_hit_data", 32'(cpu_rdata), 32'h3C);
    @(negedge clock);
    cache_flush = 1'b1;
    @(negedge clock);
    cache_flush = 1'b0;
    cpu_read(18'h08000, 1, saw, faddr, ccyc);
    check("cache_flush_mem", 32'(saw), 1);
    check("cache_flush_cyc", ccyc, 2);
`else
    // Without the cache a repeated CPU read always goes to memory
    cpu_read(18'h08000, 1, saw, faddr, ccyc);
    cpu_read(18'h08000, 1, saw, faddr, ccyc);
    check("nocache_mem", 32'(saw), 1);
    check("nocache_cyc", ccyc, 2);
    check("nocache_data", 32'(cpu_rdata), 32'h3C);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
